// File: rtl/axi_arb_pkg.sv
// Shared constants for the 3-master AXI3 arbiter: master indices, FSM state
// encodings and the round-robin successor helper.
package axi_arb_pkg;

    localparam int NUM_MASTERS = 3;

    localparam logic [1:0] M_ICACHE   = 2'd0;
    localparam logic [1:0] M_DCACHE   = 2'd1;
    localparam logic [1:0] M_UNCACHED = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    function automatic logic [1:0] next_master(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational 3-way grant selection. ARB_ROUND_ROBIN_EN selects round-robin
// from last+1; otherwise fixed priority dcache > uncached > icache.
module arb_pick
    import axi_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [1:0]             last,
`endif
    output logic [1:0]             gnt,
    output logic                   gnt_vld
);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] cand;
    logic       found;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        cand    = last;
        gnt_vld = |req;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = next_master(cand);
            if (req[cand] && !found) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_vld = |req;
        if (req[M_DCACHE])        gnt = M_DCACHE;
        else if (req[M_UNCACHED]) gnt = M_UNCACHED;
        else if (req[M_ICACHE])   gnt = M_ICACHE;
    end
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// Three upstream AXI3 masters onto one downstream port; independent read and
// write FSMs, one outstanding transaction each. Option: ARB_ROUND_ROBIN_EN.
module axi_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 4
) (
    input  logic                                  aclk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0] s_arid,
    input  logic [NUM_MASTERS-1:0][31:0]          s_araddr,
    input  logic [NUM_MASTERS-1:0][3:0]           s_arlen,
    input  logic [NUM_MASTERS-1:0][2:0]           s_arsize,
    input  logic [NUM_MASTERS-1:0][1:0]           s_arburst,
    input  logic [NUM_MASTERS-1:0][1:0]           s_arlock,
    input  logic [NUM_MASTERS-1:0][3:0]           s_arcache,
    input  logic [NUM_MASTERS-1:0][2:0]           s_arprot,
    input  logic [NUM_MASTERS-1:0]                s_arvalid,
    output logic [NUM_MASTERS-1:0]                s_arready,
    output logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0] s_rid,
    output logic [NUM_MASTERS-1:0][31:0]          s_rdata,
    output logic [NUM_MASTERS-1:0][1:0]           s_rresp,
    output logic [NUM_MASTERS-1:0]                s_rlast,
    output logic [NUM_MASTERS-1:0]                s_rvalid,
    input  logic [NUM_MASTERS-1:0]                s_rready,
    input  logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0] s_awid,
    input  logic [NUM_MASTERS-1:0][31:0]          s_awaddr,
    input  logic [NUM_MASTERS-1:0][3:0]           s_awlen,
    input  logic [NUM_MASTERS-1:0][2:0]           s_awsize,
    input  logic [NUM_MASTERS-1:0][1:0]           s_awburst,
    input  logic [NUM_MASTERS-1:0][1:0]           s_awlock,
    input  logic [NUM_MASTERS-1:0][3:0]           s_awcache,
    input  logic [NUM_MASTERS-1:0][2:0]           s_awprot,
    input  logic [NUM_MASTERS-1:0]                s_awvalid,
    output logic [NUM_MASTERS-1:0]                s_awready,
    input  logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0] s_wid,
    input  logic [NUM_MASTERS-1:0][31:0]          s_wdata,
    input  logic [NUM_MASTERS-1:0][3:0]           s_wstrb,
    input  logic [NUM_MASTERS-1:0]                s_wlast,
    input  logic [NUM_MASTERS-1:0]                s_wvalid,
    output logic [NUM_MASTERS-1:0]                s_wready,
    output logic [NUM_MASTERS-1:0][BUS_WIDTH-1:0] s_bid,
    output logic [NUM_MASTERS-1:0][1:0]           s_bresp,
    output logic [NUM_MASTERS-1:0]                s_bvalid,
    input  logic [NUM_MASTERS-1:0]                s_bready,
    output logic [BUS_WIDTH-1:0]                  m_arid,
    output logic [31:0]                           m_araddr,
    output logic [3:0]                            m_arlen,
    output logic [2:0]                            m_arsize,
    output logic [1:0]                            m_arburst,
    output logic [1:0]                            m_arlock,
    output logic [3:0]                            m_arcache,
    output logic [2:0]                            m_arprot,
    output logic                                  m_arvalid,
    input  logic                                  m_arready,
    input  logic [BUS_WIDTH-1:0]                  m_rid,
    input  logic [31:0]                           m_rdata,
    input  logic [1:0]                            m_rresp,
    input  logic                                  m_rlast,
    input  logic                                  m_rvalid,
    output logic                                  m_rready,
    output logic [BUS_WIDTH-1:0]                  m_awid,
    output logic [31:0]                           m_awaddr,
    output logic [3:0]                            m_awlen,
    output logic [2:0]                            m_awsize,
    output logic [1:0]                            m_awburst,
    output logic [1:0]                            m_awlock,
    output logic [3:0]                            m_awcache,
    output logic [2:0]                            m_awprot,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [BUS_WIDTH-1:0]                  m_wid,
    output logic [31:0]                           m_wdata,
    output logic [3:0]                            m_wstrb,
    output logic                                  m_wlast,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    input  logic [BUS_WIDTH-1:0]                  m_bid,
    input  logic [1:0]                            m_bresp,
    input  logic                                  m_bvalid,
    output logic                                  m_bready
);

    logic [1:0] r_state_q, r_state_d, w_state_q, w_state_d;
    logic [1:0] rg_q, rg_d, wg_q, wg_d;
    logic [1:0] r_pick, w_pick;
    logic       r_pick_vld, w_pick_vld;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;

    arb_pick u_r_pick (.req(s_arvalid), .last(r_ptr_q), .gnt(r_pick), .gnt_vld(r_pick_vld));
    arb_pick u_w_pick (.req(s_awvalid), .last(w_ptr_q), .gnt(w_pick), .gnt_vld(w_pick_vld));
`else
    arb_pick u_r_pick (.req(s_arvalid), .gnt(r_pick), .gnt_vld(r_pick_vld));
    arb_pick u_w_pick (.req(s_awvalid), .gnt(w_pick), .gnt_vld(w_pick_vld));
`endif

    // Read path: the grant index only steers muxes outside R_IDLE, so all
    // downstream signals fall to zero whenever the FSM is idle or in reset.
    always_comb begin
        r_state_d = r_state_q;
        rg_d      = rg_q;
`ifdef ARB_ROUND_ROBIN_EN
        r_ptr_d   = r_ptr_q;
`endif
        {m_arid, m_araddr, m_arlen, m_arsize, m_arburst} = '0;
        {m_arlock, m_arcache, m_arprot, m_arvalid}        = '0;
        s_arready = '0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        case (r_state_q)
            R_IDLE: if (r_pick_vld) begin
                rg_d      = r_pick;
                r_state_d = R_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                r_ptr_d   = r_pick;
`endif
            end
            R_ADDR: begin
                m_arid    = s_arid[rg_q];
                m_araddr  = s_araddr[rg_q];
                m_arlen   = s_arlen[rg_q];
                m_arsize  = s_arsize[rg_q];
                m_arburst = s_arburst[rg_q];
                m_arlock  = s_arlock[rg_q];
                m_arcache = s_arcache[rg_q];
                m_arprot  = s_arprot[rg_q];
                m_arvalid = s_arvalid[rg_q];
                s_arready[rg_q] = m_arready;
                if (m_arvalid && m_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_rid[rg_q]    = m_rid;
                s_rdata[rg_q]  = m_rdata;
                s_rresp[rg_q]  = m_rresp;
                s_rlast[rg_q]  = m_rlast;
                s_rvalid[rg_q] = m_rvalid;
                m_rready       = s_rready[rg_q];
                if (m_rvalid && m_rready && m_rlast) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path: W is only opened after the AW handshake, which keeps data
    // from racing ahead of its address.
    always_comb begin
        w_state_d = w_state_q;
        wg_d      = wg_q;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_d   = w_ptr_q;
`endif
        {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst} = '0;
        {m_awlock, m_awcache, m_awprot, m_awvalid}        = '0;
        {m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid}      = '0;
        s_awready = '0;
        s_wready  = '0;
        s_bid     = '0;
        s_bresp   = '0;
        s_bvalid  = '0;
        m_bready  = 1'b0;
        case (w_state_q)
            W_IDLE: if (w_pick_vld) begin
                wg_d      = w_pick;
                w_state_d = W_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                w_ptr_d   = w_pick;
`endif
            end
            W_ADDR: begin
                m_awid    = s_awid[wg_q];
                m_awaddr  = s_awaddr[wg_q];
                m_awlen   = s_awlen[wg_q];
                m_awsize  = s_awsize[wg_q];
                m_awburst = s_awburst[wg_q];
                m_awlock  = s_awlock[wg_q];
                m_awcache = s_awcache[wg_q];
                m_awprot  = s_awprot[wg_q];
                m_awvalid = s_awvalid[wg_q];
                s_awready[wg_q] = m_awready;
                if (m_awvalid && m_awready) w_state_d = W_DATA;
            end
            W_DATA: begin
                m_wid    = s_wid[wg_q];
                m_wdata  = s_wdata[wg_q];
                m_wstrb  = s_wstrb[wg_q];
                m_wlast  = s_wlast[wg_q];
                m_wvalid = s_wvalid[wg_q];
                s_wready[wg_q] = m_wready;
                if (m_wvalid && m_wready && m_wlast) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_bid[wg_q]    = m_bid;
                s_bresp[wg_q]  = m_bresp;
                s_bvalid[wg_q] = m_bvalid;
                m_bready       = s_bready[wg_q];
                if (m_bvalid && m_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            rg_q      <= '0;
            wg_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr_q   <= 2'd2;
            w_ptr_q   <= 2'd2;
`endif
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            rg_q      <= rg_d;
            wg_q      <= wg_d;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr_q   <= r_ptr_d;
            w_ptr_q   <= w_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter: reset, single read,
// contention, concurrent read/write, backpressure, early W and mid-burst reset.
module tb_axi_master_arbiter;
    localparam int BW = 4;

    logic aclk = 1'b0, reset = 1'b1;
    logic [2:0][BW-1:0] s_arid, s_awid, s_wid, s_rid, s_bid;
    logic [2:0][31:0]   s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [2:0][3:0]    s_arlen, s_arcache, s_awlen, s_awcache, s_wstrb;
    logic [2:0][2:0]    s_arsize, s_arprot, s_awsize, s_awprot;
    logic [2:0][1:0]    s_arburst, s_arlock, s_awburst, s_awlock, s_rresp, s_bresp;
    logic [2:0]         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [2:0]         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [BW-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
    logic [31:0]   m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0]    m_arlen, m_arcache, m_awlen, m_awcache, m_wstrb;
    logic [2:0]    m_arsize, m_arprot, m_awsize, m_awprot;
    logic [1:0]    m_arburst, m_arlock, m_rresp, m_awburst, m_awlock, m_bresp;
    logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    int checks = 0;
    int failures = 0;

    axi_master_arbiter #(.BUS_WIDTH(BW)) dut (
        .aclk(aclk), .reset(reset),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr_inputs();
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arlock = '0; s_arcache = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_awlock = '0; s_awcache = '0; s_awprot = '0; s_awvalid = '0;
        s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        reset = 1'b1;
        s_arvalid = 3'b111; s_awvalid = 3'b111; s_wvalid = 3'b111;
        m_arready = 1; m_awready = 1; m_wready = 1; m_rvalid = 1; m_bvalid = 1;
        s_rready = 3'b111; s_bready = 3'b111;
        step(); step();
        checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL rst_m_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (m_awvalid !== 1'b0) begin failures++; $display("FAIL rst_m_awvalid got=%b exp=0", m_awvalid); end
        checks++; if ({s_arready, s_awready, s_wready} !== 9'b0) begin failures++; $display("FAIL rst_s_readies got=%b exp=0", {s_arready, s_awready, s_wready}); end
        checks++; if ({s_rvalid, s_bvalid, m_rready, m_bready, m_wvalid} !== 9'b0) begin failures++; $display("FAIL rst_misc got=%b exp=0", {s_rvalid, s_bvalid, m_rready, m_bready, m_wvalid}); end
        checks++; if (m_araddr !== 32'h0) begin failures++; $display("FAIL rst_m_araddr got=%h exp=0", m_araddr); end
    endtask

    task automatic test_single_read();
        do_reset();
        s_arvalid[0] = 1'b1; s_araddr[0] = 32'h1FC00000; s_arlen[0] = 4'd3; s_arid[0] = 4'h3;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL rd_idle_arvalid got=%b exp=0", m_arvalid); end
        step();
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h1FC00000) begin failures++; $display("FAIL rd_addr got=%b/%h exp=1/1fc00000", m_arvalid, m_araddr); end
        checks++; if (m_arlen !== 4'd3 || m_arid !== 4'h3) begin failures++; $display("FAIL rd_len_id got=%h/%h exp=3/3", m_arlen, m_arid); end
        m_arready = 1'b1;
        #1;
        checks++; if (s_arready !== 3'b001) begin failures++; $display("FAIL rd_arready got=%b exp=001", s_arready); end
        step();
        s_arvalid = '0; m_arready = 1'b0; s_rready = 3'b111;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rdata = 32'hA000_0000 + b; m_rlast = (b == 3);
            #1;
            checks++; if (s_rvalid !== 3'b001 || s_rdata[0] !== 32'hA000_0000 + b) begin failures++; $display("FAIL rd_beat%0d got=%b/%h exp=001/%h", b, s_rvalid, s_rdata[0], 32'hA000_0000 + b); end
            checks++; if (s_rdata[1] !== 32'h0 || s_rdata[2] !== 32'h0 || m_rready !== 1'b1) begin failures++; $display("FAIL rd_beat%0d_iso got=%h/%h/%b exp=0/0/1", b, s_rdata[1], s_rdata[2], m_rready); end
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        checks++; if (m_rready !== 1'b0 || s_rvalid !== 3'b000) begin failures++; $display("FAIL rd_back_idle got=%b/%b exp=0/000", m_rready, s_rvalid); end
    endtask

    task automatic test_contention();
        int exp_order[4];
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) s_araddr[i] = 32'h1000 * (i + 1);
        s_arvalid = 3'b111; m_arready = 1; m_rvalid = 1; m_rlast = 1; s_rready = 3'b111;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (m_arvalid !== 1'b1 && n < 10) begin step(); n++; end
            checks++;
            if (n >= 10) begin
                failures++; $display("FAIL cont_timeout grant%0d got=no_arvalid exp=arvalid", k);
            end else if (m_araddr !== 32'h1000 * (exp_order[k] + 1)) begin
                failures++; $display("FAIL cont_grant%0d got=%h exp=%h", k, m_araddr, 32'h1000 * (exp_order[k] + 1));
            end
            step();
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        s_awvalid[1] = 1; s_awaddr[1] = 32'h80001000; s_awlen[1] = 0;
        s_wvalid[1] = 1; s_wdata[1] = 32'hDEADBEEF; s_wstrb[1] = 4'hF; s_wlast[1] = 1;
        s_arvalid[2] = 1; s_araddr[2] = 32'h20000040;
        m_arready = 1; m_awready = 1; m_wready = 1;
        step();
        checks++; if (m_awvalid !== 1 || m_awaddr !== 32'h80001000 || s_awready !== 3'b010) begin failures++; $display("FAIL conc_aw got=%b/%h/%b exp=1/80001000/010", m_awvalid, m_awaddr, s_awready); end
        checks++; if (m_arvalid !== 1 || m_araddr !== 32'h20000040 || s_arready !== 3'b100) begin failures++; $display("FAIL conc_ar got=%b/%h/%b exp=1/20000040/100", m_arvalid, m_araddr, s_arready); end
        checks++; if (s_wready !== 3'b000 || m_wvalid !== 1'b0) begin failures++; $display("FAIL conc_w_early got=%b/%b exp=000/0", s_wready, m_wvalid); end
        step();
        s_awvalid = '0; s_arvalid = '0;
        m_rvalid = 1; m_rlast = 1; m_rdata = 32'h12345678; s_rready[2] = 1;
        #1;
        checks++; if (m_wvalid !== 1 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF || s_wready !== 3'b010) begin failures++; $display("FAIL conc_w got=%b/%h/%h/%b exp=1/deadbeef/f/010", m_wvalid, m_wdata, m_wstrb, s_wready); end
        checks++; if (s_rvalid !== 3'b100 || s_rdata[2] !== 32'h12345678) begin failures++; $display("FAIL conc_r got=%b/%h exp=100/12345678", s_rvalid, s_rdata[2]); end
        step();
        s_wvalid = '0; m_rvalid = 0; m_bvalid = 1; m_bresp = 2'b01; m_bid = 4'h5; s_bready = 3'b010;
        #1;
        checks++; if (s_bvalid !== 3'b010 || s_bresp[1] !== 2'b01 || s_bid[1] !== 4'h5) begin failures++; $display("FAIL conc_b got=%b/%b/%h exp=010/01/5", s_bvalid, s_bresp[1], s_bid[1]); end
        checks++; if (s_bresp[0] !== 2'b00 || s_bresp[2] !== 2'b00 || m_bready !== 1'b1) begin failures++; $display("FAIL conc_b_iso got=%b/%b/%b exp=00/00/1", s_bresp[0], s_bresp[2], m_bready); end
        step();
        m_bvalid = 0;
        #1;
        checks++; if (m_bready !== 1'b0 || s_bvalid !== 3'b000) begin failures++; $display("FAIL conc_b_done got=%b/%b exp=0/000", m_bready, s_bvalid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        s_arvalid[0] = 1; s_araddr[0] = 32'h0000_0A00;
        step();
        s_arvalid = 3'b111; s_araddr[1] = 32'h0000_0B00; s_araddr[2] = 32'h0000_0C00;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (m_arvalid !== 1 || m_araddr !== 32'h0A00 || s_arready !== 3'b000) begin failures++; $display("FAIL bp_cycle%0d got=%b/%h/%b exp=1/00000a00/000", c, m_arvalid, m_araddr, s_arready); end
            step();
        end
        m_arready = 1;
        #1;
        checks++; if (s_arready !== 3'b001 || m_araddr !== 32'h0A00) begin failures++; $display("FAIL bp_release got=%b/%h exp=001/00000a00", s_arready, m_araddr); end
        step();
    endtask

    task automatic test_early_w();
        do_reset();
        s_wvalid[1] = 1; s_wdata[1] = 32'hCAFE0001; s_wlast[1] = 1; m_wready = 1;
        #1;
        checks++; if (s_wready !== 3'b000 || m_wvalid !== 1'b0) begin failures++; $display("FAIL ew_pre got=%b/%b exp=000/0", s_wready, m_wvalid); end
        step();
        checks++; if (s_wready !== 3'b000) begin failures++; $display("FAIL ew_idle got=%b exp=000", s_wready); end
        s_awvalid[1] = 1; s_awaddr[1] = 32'h8000_2000;
        step();
        checks++; if (s_wready !== 3'b000 || m_awvalid !== 1'b1) begin failures++; $display("FAIL ew_addr got=%b/%b exp=000/1", s_wready, m_awvalid); end
        step();
        checks++; if (s_wready !== 3'b000) begin failures++; $display("FAIL ew_stall got=%b exp=000", s_wready); end
        m_awready = 1;
        step();
        s_awvalid = '0;
        #1;
        checks++; if (s_wready !== 3'b010 || m_wvalid !== 1'b1 || m_wdata !== 32'hCAFE0001) begin failures++; $display("FAIL ew_pass got=%b/%b/%h exp=010/1/cafe0001", s_wready, m_wvalid, m_wdata); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        s_arvalid[2] = 1; s_araddr[2] = 32'h3000_0000; s_arlen[2] = 3; m_arready = 1;
        step(); step();
        s_arvalid = '0; m_rvalid = 1; m_rlast = 0; s_rready = 3'b100;
        step(); step();
        #1;
        checks++; if (s_rvalid !== 3'b100) begin failures++; $display("FAIL rmb_pre got=%b exp=100", s_rvalid); end
        s_arvalid[1] = 1; s_araddr[1] = 32'h4000_0010;
        reset = 1'b1;
        #1;
        checks++; if (s_rvalid !== 3'b000 || m_rready !== 1'b0 || m_arvalid !== 1'b0 || s_arready !== 3'b000) begin failures++; $display("FAIL rmb_abort got=%b/%b/%b/%b exp=000/0/0/000", s_rvalid, m_rready, m_arvalid, s_arready); end
        m_rvalid = 0;
        step();
        reset = 1'b0;
        step();
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h4000_0010 || s_arready !== 3'b010) begin failures++; $display("FAIL rmb_regrant got=%b/%h/%b exp=1/40000010/010", m_arvalid, m_araddr, s_arready); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_concurrent();
        test_backpressure();
        test_early_w();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
